// File: rtl/minv_mdiv_host_seq.sv
// Host-side sequencer for the MINV_MDIV core: loads a/p/b word-serially, starts
// the core, waits for ready with a timeout, then reassembles both result registers.
module minv_mdiv_host_seq #(
  parameter int unsigned W       = 32,
  parameter int unsigned WORDS   = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [W*WORDS-1:0]   op_a,
  input  logic [W*WORDS-1:0]   op_b,
  input  logic [W*WORDS-1:0]   op_p,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [W*WORDS-1:0]   res_x1,
  output logic [W*WORDS-1:0]   res_x2,
  output logic                 res_flag,
  output logic [W-1:0]         datain,
  output logic                 loada,
  output logic                 loadb,
  output logic                 loadp,
  output logic                 minv_mdiv,
  output logic                 minv_mdiv_en,
  output logic                 outx1,
  output logic                 outx2,
  input  logic [W-1:0]         regx1out,
  input  logic [W-1:0]         regx2out,
  input  logic                 minv_mdiv_rdy,
  input  logic                 minv_mdiv_flag
);

  localparam int unsigned OPW = W * WORDS;
  localparam int unsigned KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned RN  = RD_LAT + WORDS;
  localparam int unsigned RW  = (RN > 1) ? $clog2(RN) : 1;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RN - 1);
  localparam logic [RW-1:0] R_LAT  = RW'(RD_LAT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_A   = 3'd1;
  localparam logic [2:0] LOAD_P   = 3'd2;
  localparam logic [2:0] LOAD_B   = 3'd3;
  localparam logic [2:0] GO       = 3'd4;
  localparam logic [2:0] WAIT_RDY = 3'd5;
  localparam logic [2:0] READ     = 3'd6;
  localparam logic [2:0] FIN      = 3'd7;

  logic [2:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d, ridx;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic [TW-1:0]  wcnt_q, wcnt_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic           mode_q, mode_d;
  logic [OPW-1:0] x1_d, x2_d;
  logic           flag_d, err_d;
  logic [W-1:0]   datain_d;
  logic           loada_d, loadb_d, loadp_d, en_d, outx_d, done_d, busy_d, minv_d;

  // State, operand latches and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      rcnt_q       <= '0;
      wcnt_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      p_q          <= '0;
      mode_q       <= 1'b0;
      res_x1       <= '0;
      res_x2       <= '0;
      res_flag     <= 1'b0;
      err          <= 1'b0;
      datain       <= '0;
      loada        <= 1'b0;
      loadb        <= 1'b0;
      loadp        <= 1'b0;
      minv_mdiv_en <= 1'b0;
      outx1        <= 1'b0;
      outx2        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      minv_mdiv    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rcnt_q       <= rcnt_d;
      wcnt_q       <= wcnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      mode_q       <= mode_d;
      res_x1       <= x1_d;
      res_x2       <= x2_d;
      res_flag     <= flag_d;
      err          <= err_d;
      datain       <= datain_d;
      loada        <= loada_d;
      loadb        <= loadb_d;
      loadp        <= loadp_d;
      minv_mdiv_en <= en_d;
      outx1        <= outx_d;
      outx2        <= outx_d;
      done         <= done_d;
      busy         <= busy_d;
      minv_mdiv    <= minv_d;
    end
  end

  // Next state; outputs are derived from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    mode_d  = mode_q;
    x1_d    = res_x1;
    x2_d    = res_x2;
    flag_d  = res_flag;
    err_d   = err;
    ridx    = KW'(rcnt_q - R_LAT);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          k_d     = '0;
          a_d     = op_a;
          b_d     = op_b;
          p_d     = op_p;
          mode_d  = mode;
          err_d   = 1'b0;
        end
      end
      LOAD_A: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = LOAD_P;
          k_d     = '0;
        end
      end
      LOAD_P: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = mode_q ? GO : LOAD_B;
          k_d     = '0;
        end
      end
      LOAD_B: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = GO;
          k_d     = '0;
        end
      end
      GO: begin
        state_d = WAIT_RDY;
        wcnt_d  = '0;
      end
      WAIT_RDY: begin
        if (minv_mdiv_rdy) begin
          flag_d  = minv_mdiv_flag;
          state_d = READ;
          rcnt_d  = '0;
        end else if (wcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      READ: begin
        // Words arrive RD_LAT cycles after the readout enables rise
        if (rcnt_q >= R_LAT) begin
          x1_d[ridx*W +: W] = regx1out;
          x2_d[ridx*W +: W] = regx2out;
        end
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == R_LAST) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    datain_d = '0;
    case (state_d)
      LOAD_A:  datain_d = a_d[k_d*W +: W];
      LOAD_P:  datain_d = p_d[k_d*W +: W];
      LOAD_B:  datain_d = b_d[k_d*W +: W];
      default: datain_d = '0;
    endcase
    loada_d = (state_d == LOAD_A);
    loadp_d = (state_d == LOAD_P);
    loadb_d = (state_d == LOAD_B);
    en_d    = (state_d == GO);
    outx_d  = (state_d == READ);
    done_d  = (state_d == FIN);
    busy_d  = (state_d != IDLE) && (state_d != FIN);
    minv_d  = (state_d != IDLE) && mode_d;
  end

endmodule

// File: tb/tb_minv_mdiv_host_seq.sv
// Scoreboard bench for minv_mdiv_host_seq with a small behavioural MINV_MDIV core model.
module tb_minv_mdiv_host_seq;
  localparam int unsigned W       = 32;
  localparam int unsigned WORDS   = 8;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned TIMEOUT = 100;

  localparam logic [255:0] A_DIV = 256'h32C4AE2C_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01234567_89ABCDEF_334C74C7;
  localparam logic [255:0] B_DIV = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
  localparam logic [255:0] P_DIV = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] X1_DIV = 256'h11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001;
  localparam logic [255:0] X2_DIV = 256'h80000000_00000001_7FFFFFFF_FFFFFFFE_0BADF00D_CAFEBABE_12345678_9ABCDEF0;
  localparam logic [255:0] X1_NEW = 256'h0000000A_0000000B_0000000C_0000000D_0000000E_0000000F_00000010_00000011;
  localparam logic [255:0] X2_NEW = 256'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [255:0] op_a, op_b, op_p, res_x1, res_x2;
  logic busy, done, err, res_flag;
  logic [W-1:0] datain, regx1out, regx2out;
  logic loada, loadb, loadp, minv_mdiv, minv_mdiv_en, outx1, outx2;
  logic minv_mdiv_rdy, minv_mdiv_flag;

  minv_mdiv_host_seq #(.W(W), .WORDS(WORDS), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b), .op_p(op_p),
    .busy(busy), .done(done), .err(err), .res_x1(res_x1), .res_x2(res_x2), .res_flag(res_flag),
    .datain(datain), .loada(loada), .loadb(loadb), .loadp(loadp), .minv_mdiv(minv_mdiv),
    .minv_mdiv_en(minv_mdiv_en), .outx1(outx1), .outx2(outx2), .regx1out(regx1out),
    .regx2out(regx2out), .minv_mdiv_rdy(minv_mdiv_rdy), .minv_mdiv_flag(minv_mdiv_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: rdy m_delay cycles after the en pulse, words 0..7 from RD_LAT after outx1 rises
  int m_delay = 0;
  logic m_rdy_en = 1'b0, m_flag = 1'b0;
  logic [255:0] m_x1 = '0, m_x2 = '0;
  int wait_ctr = 0, rd_ctr = 0;
  always @(posedge clk) begin
    if (rst) begin
      wait_ctr <= 0;
      rd_ctr   <= 0;
    end else begin
      if (minv_mdiv_en) wait_ctr <= 1;
      else if (wait_ctr != 0 && wait_ctr < 1000) wait_ctr <= wait_ctr + 1;
      rd_ctr <= outx1 ? rd_ctr + 1 : 0;
    end
  end
  assign minv_mdiv_rdy  = m_rdy_en && (wait_ctr == m_delay);
  assign minv_mdiv_flag = m_flag;
  always_comb begin
    regx1out = 32'hDEADBEEF;
    regx2out = 32'hDEADBEEF;
    if (rd_ctr >= 1 && rd_ctr <= int'(WORDS)) begin
      regx1out = m_x1[32*(rd_ctr-1) +: 32];
      regx2out = m_x2[32*(rd_ctr-1) +: 32];
    end
  end

  typedef struct {
    int kind;
    int cyc;
    logic [255:0] d1;
    logic [255:0] d2;
    logic e;
    logic f;
  } ev_t;
  ev_t exp_q[$];
  string kname [6] = '{"none", "loada", "loadp", "loadb", "en", "done"};
  int vectors = 0, miscompares = 0;
  logic exp_mode = 1'b0, no_read = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input logic [255:0] d1, input logic [255:0] d2,
                         input logic e, input logic f);
    ev_t ev;
    ev.kind = kind; ev.cyc = c; ev.d1 = d1; ev.d2 = d2; ev.e = e; ev.f = f;
    exp_q.push_back(ev);
  endtask

  // Drive one request (cycle 0 = edge that samples start) and queue its expected responses
  task automatic issue(input logic md, input logic [255:0] a, input logic [255:0] b, input logic [255:0] p,
                       input logic [255:0] ex1, input logic [255:0] ex2, input logic eerr, input logic efl);
    int s, e;
    s = cyc;
    for (int k = 0; k < 8; k++) push_ev(1, s + 1 + k, 256'(a[32*k +: 32]), '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push_ev(2, s + 9 + k, 256'(p[32*k +: 32]), '0, 1'b0, 1'b0);
    if (!md) for (int k = 0; k < 8; k++) push_ev(3, s + 17 + k, 256'(b[32*k +: 32]), '0, 1'b0, 1'b0);
    e = md ? s + 17 : s + 25;
    push_ev(4, e, '0, '0, 1'b0, 1'b0);
    push_ev(5, m_rdy_en ? e + m_delay + 10 : e + 101, ex1, ex2, eerr, efl);
    op_a = a; op_b = b; op_p = p; mode = md; exp_mode = md; start = 1'b1;
  endtask

  task automatic pop_chk(input int kind, input logic [255:0] d);
    ev_t ev;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s at cycle %0d: got strobe, required none", kname[kind], cyc);
      return;
    end
    vectors--;
    ev = exp_q.pop_front();
    chk($sformatf("%s_kind", kname[kind]), 256'(kind), 256'(ev.kind));
    chk($sformatf("%s_cycle", kname[kind]), 256'(cyc), 256'(ev.cyc));
    chk($sformatf("%s_mode", kname[kind]), 256'(minv_mdiv), 256'(exp_mode));
    if (kind <= 3) chk($sformatf("%s_datain", kname[kind]), d, ev.d1);
    if (kind == 5) begin
      chk("done_res_x1", res_x1, ev.d1);
      chk("done_res_x2", res_x2, ev.d2);
      chk("done_err", 256'(err), 256'(ev.e));
      chk("done_res_flag", 256'(res_flag), 256'(ev.f));
      chk("done_busy", 256'(busy), 256'(1'b0));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (loada | loadb | loadp) chk("load_onehot", 256'($countones({loada, loadb, loadp})), 256'(1));
      else if (datain != '0) chk("datain_idle", 256'(datain), 256'(0));
      if (outx1 | outx2) chk("outx_pair", 256'(outx1), 256'(outx2));
      if (no_read) chk("outx1_on_timeout", 256'(outx1), 256'(1'b0));
      if (loada)        pop_chk(1, 256'(datain));
      if (loadp)        pop_chk(2, 256'(datain));
      if (loadb)        pop_chk(3, 256'(datain));
      if (minv_mdiv_en) pop_chk(4, '0);
      if (done)         pop_chk(5, '0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy), '0);
    chk({tag, "_done"}, 256'(done), '0);
    chk({tag, "_err"}, 256'(err), '0);
    chk({tag, "_flag"}, 256'(res_flag), '0);
    chk({tag, "_res_x1"}, res_x1, '0);
    chk({tag, "_res_x2"}, res_x2, '0);
    chk({tag, "_datain"}, 256'(datain), '0);
    chk({tag, "_strobes"}, 256'({loada, loadb, loadp, minv_mdiv_en, outx1, outx2}), '0);
    chk({tag, "_minv_mdiv"}, 256'(minv_mdiv), '0);
  endtask

  task automatic wait_done(input int budget, input bit hold);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!hold) start = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL done_wait at cycle %0d: got no done within %0d cycles, required done", cyc, budget);
    end
    @(posedge clk); #2;
    chk("after_done_busy", 256'(busy), '0);
    chk("after_done_minv_mdiv", 256'(minv_mdiv), '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; op_a = '0; op_b = '0; op_p = '0;
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2;
    chk_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #2;
    chk("rst_start_ignored", 256'(busy), '0);

    // Division with start held high the whole run
    m_delay = 40; m_rdy_en = 1'b1; m_flag = 1'b1; m_x1 = X1_DIV; m_x2 = X2_DIV;
    issue(1'b0, A_DIV, B_DIV, P_DIV, X1_DIV, X2_DIV, 1'b0, 1'b1);
    wait_done(200, 1'b1);

    // Inversion 5^-1 mod 11 = 9
    m_delay = 7; m_flag = 1'b0; m_x1 = 256'd9; m_x2 = 256'd3;
    issue(1'b1, 256'd5, 256'hFFFF, 256'd11, 256'd9, 256'd3, 1'b0, 1'b0);
    wait_done(200, 1'b0);

    // Timeout: rdy never comes, results and flag keep the previous values
    m_rdy_en = 1'b0; m_flag = 1'b1; m_x1 = X1_NEW; no_read = 1'b1;
    issue(1'b1, 256'd7, 256'd0, 256'd13, 256'd9, 256'd3, 1'b1, 1'b0);
    wait_done(300, 1'b0);
    no_read = 1'b0;

    // Reset in the middle of LOAD_P aborts the run
    m_rdy_en = 1'b1; m_delay = 5;
    issue(1'b0, A_DIV, B_DIV, P_DIV, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_loadp_active", 256'(loadp), 256'(1'b1));
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    chk_zero("mid_reset");
    repeat (20) @(posedge clk);
    #2 chk("no_done_after_abort", 256'(busy), '0);

    // Fresh division after the abort
    m_x1 = X1_NEW; m_x2 = X2_NEW; m_flag = 1'b0;
    issue(1'b0, B_DIV, A_DIV, P_DIV, X1_NEW, X2_NEW, 1'b0, 1'b0);
    wait_done(200, 1'b0);

    chk("scoreboard_empty", 256'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
